// File: rtl/uart_pkg.sv
// Shared UART types and helpers used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic int cnt_width(input int data_bits);
    return $clog2(data_bits) + 1;
  endfunction

  // Narrow words are zero-extended by the caller; the zeros do not change the XOR.
  function automatic logic par(input logic [8:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..BAUD_DIV-1 while enabled and pulses tick on the terminal count.
module uart_baud_gen #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] TERM = 16'(BAUD_DIV - 1);

  logic [15:0] count;

  assign tick = enable && (count == TERM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? 16'd0 : count + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// tx is a flop fed from next-state values, so each bit appears exactly one clock after its decision.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV      = 434,
  parameter int DATA_BITS     = 8,
  parameter int ENABLE_PARITY = 1,
  parameter int PARITY_ODD    = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CW = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  tx_state_t            state, state_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic [CW-1:0]        bit_cnt, bit_cnt_nx;
  logic                 parity_q, parity_nx;
  logic                 tx_nx, done_nx;
  logic                 tick, handshake;

  assign ready     = (state == IDLE);
  assign busy      = !ready;
  assign handshake = valid && ready;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state != IDLE),
    .clear  (handshake),
    .tick   (tick)
  );

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    parity_nx  = parity_q;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          state_nx   = START;
          shreg_nx   = data_in;
          bit_cnt_nx = '0;
          parity_nx  = (ENABLE_PARITY != 0) ? par(9'(data_in), PARITY_ODD != 0) : 1'b0;
        end
      end
      START: if (tick) state_nx = DATA;
      DATA: begin
        if (tick) begin
          shreg_nx = shreg >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_nx = '0;
            state_nx   = (ENABLE_PARITY != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_nx = bit_cnt + CW'(1);
          end
        end
      end
      PARITY: if (tick) state_nx = STOP;
      STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_nx = '0;
            state_nx   = IDLE;
            done_nx    = 1'b1;
          end else begin
            bit_cnt_nx = bit_cnt + CW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    tx_nx = 1'b1;
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg_nx[0];
      PARITY:  tx_nx = parity_nx;
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      parity_q <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      bit_cnt  <= bit_cnt_nx;
      parity_q <= parity_nx;
      tx       <= tx_nx;
      tx_done  <= done_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench: three transmitter configurations at BAUD_DIV=4, bit-exact frame checks.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       valid_v [3];
  logic       ready_v [3];
  logic       tx_v    [3];
  logic       busy_v  [3];
  logic       done_v  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // 0: even parity, 1 stop; 1: odd parity, 1 stop; 2: no parity, 2 stops
  uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .ENABLE_PARITY(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid(valid_v[0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));

  uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .ENABLE_PARITY(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid(valid_v[1]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));

  uart_tx #(.BAUD_DIV(4), .DATA_BITS(8), .ENABLE_PARITY(0), .PARITY_ODD(0), .STOP_BITS(2)) u_nopar (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid(valid_v[2]),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // exp[b] is the value of bit period b (bit 0 = start bit); each period is 4 clocks.
  task automatic run_bits(input int idx, input logic [10:0] exp, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 4; c++) begin
        chk("tx_bit", {31'd0, tx_v[idx]}, {31'd0, exp[b]});
        chk("ready_low", {31'd0, ready_v[idx]}, 32'd0);
        chk("busy_high", {31'd0, busy_v[idx]}, 32'd1);
        chk("no_done", {31'd0, done_v[idx]}, 32'd0);
        @(negedge clk);
      end
    end
  endtask

  task automatic handshake(input int idx, input logic [7:0] d);
    data_in      = d;
    valid_v[idx] = 1'b1;
    chk("ready_before", {31'd0, ready_v[idx]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid_v[idx] = 1'b0;
  endtask

  task automatic finish_frame(input int idx);
    chk("done_pulse", {31'd0, done_v[idx]}, 32'd1);
    chk("ready_back", {31'd0, ready_v[idx]}, 32'd1);
    chk("tx_idle", {31'd0, tx_v[idx]}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done_v[idx]}, 32'd0);
  endtask

  task automatic send(input int idx, input logic [7:0] d, input logic [10:0] exp, input int nbits);
    handshake(idx, d);
    run_bits(idx, exp, nbits);
    finish_frame(idx);
  endtask

  initial begin
    rst_n   = 1'b0;
    data_in = 8'h00;
    for (int i = 0; i < 3; i++) valid_v[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_tx", {31'd0, tx_v[i]}, 32'd1);
      chk("rst_ready", {31'd0, ready_v[i]}, 32'd1);
      chk("rst_busy", {31'd0, busy_v[i]}, 32'd0);
      chk("rst_done", {31'd0, done_v[i]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,par 0,stop 1
    send(0, 8'hA5, 11'h54A, 11);
    // odd parity: 0x00 -> parity 1, 0xFF -> parity 1
    send(1, 8'h00, 11'h600, 11);
    send(1, 8'hFF, 11'h7FE, 11);
    // no parity, two stop bits: 0x3C
    send(2, 8'h3C, 11'h678, 11);

    // back-to-back with valid held; data_in changes mid-frame without effect
    data_in    = 8'h11;
    valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_in = 8'h22;
    run_bits(0, 11'h422, 11);
    chk("b2b_done", {31'd0, done_v[0]}, 32'd1);
    chk("b2b_gap_tx", {31'd0, tx_v[0]}, 32'd1);
    chk("b2b_ready", {31'd0, ready_v[0]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid_v[0] = 1'b0;
    run_bits(0, 11'h444, 11);
    finish_frame(0);

    // reset at clock 10 of a frame
    handshake(0, 8'hA5);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy_v[0]}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx", {31'd0, tx_v[0]}, 32'd1);
    chk("midrst_ready", {31'd0, ready_v[0]}, 32'd1);
    chk("midrst_done", {31'd0, done_v[0]}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_done", {31'd0, done_v[0]}, 32'd0);
      chk("post_rst_tx", {31'd0, tx_v[0]}, 32'd1);
    end
    send(0, 8'h5A, 11'h4B4, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter: serialises a parallel word onto the `tx` line as start bit, data bits (LSB first), optional parity bit, then one or two stop bits. It is the upstream partner of the receiver. It drives the serial line that the receiver samples, and loopback benches wire the two together directly. A system-side producer hands it words through a valid/ready handshake.

Parameters:
BAUD_DIV, 434, clocks per bit period (115200 baud at 50 MHz); legal range 2..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
ENABLE_PARITY, 1, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when ENABLE_PARITY=0
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
data_in  in  DATA_BITS  word to transmit; sampled only on handshake
valid  in  1  producer has a word on data_in
ready  out  1  transmitter can accept a word; high only in IDLE
tx  out  1  serial line, registered, idles high
busy  out  1  high while a frame is in progress (= !ready)
tx_done  out  1  one-cycle pulse when a frame's final stop bit completes

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n`, synchronous, active-low. All state changes on posedge clk. No second clock domain; no edge-derived clocks.
- Reset (rst_n low at a clock edge): state=IDLE, tx=1, ready=1, busy=0, tx_done=0, baud counter=0, bit counter=0, shift register=0.
- Reset mid-frame: the frame is abandoned. tx returns to 1 at the next edge. No tx_done pulse.
- Handshake: a word is accepted at edge T when valid && ready.
  - data_in is latched into the shift register.
  - Parity is computed from the latched word: XOR of all bits, inverted if PARITY_ODD.
  - Edge T moves to START, so in cycle T+1: tx=0, ready=0, busy=1.
- valid while busy: ignored. No queuing, no error.
- data_in changes during a frame: no effect on the frame.
- Baud counter: 16-bit, counts 0..BAUD_DIV-1 in every non-IDLE state and wraps at terminal count. Each bit is held on tx for exactly BAUD_DIV clocks. The counter is cleared on every handshake.
- State machine (advances only on baud terminal count, except IDLE):
  - IDLE: tx=1. Go to START on handshake.
  - START: tx=0. Go to DATA.
  - DATA: tx = shift register bit 0. The register shifts right each bit period. The bit counter runs 0..DATA_BITS-1. At the last bit, go to PARITY if ENABLE_PARITY, else go to STOP.
  - PARITY: tx = parity bit. Go to STOP.
  - STOP: tx=1. The stop-bit counter runs 0..STOP_BITS-1. After the last stop bit, go to IDLE and assert tx_done for exactly that one cycle (the first IDLE cycle).
- Frame length from handshake:
  - (1 + DATA_BITS + ENABLE_PARITY + STOP_BITS) * BAUD_DIV clocks.
  - ready rises on the cycle after the last stop-bit clock.
- Back-to-back frames: a new handshake is legal in the same cycle tx_done is high. The next start bit then begins one clock later, so the minimum idle-high gap between frames is 1 clock.
- tx is glitch-free: driven directly from a flop, never combinationally from state.

Decomposition:
- Shared package `uart_pkg`:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding.
  - Localparam helper for the counter width: $clog2 of DATA_BITS, plus 1.
  - Parity function par(word, odd), reused by the receiver's checker.
- One sub-module is natural: `uart_baud_gen`.
  - Inputs: clk, rst_n, enable, clear.
  - Output: tick, a one-cycle pulse at BAUD_DIV-1.
  - Shared with the receiver so both sides use an identical divider.

Test Plan:
- BAUD_DIV=4, 8 bits, even parity, 1 stop; send 0xA5 → tx holds each of the following for 4 clks: 0,1,0,1,0,0,1,0,1,0(parity),1. tx_done at handshake+45. ready low for 44 cycles.
- Same config, PARITY_ODD=1, send 0x00 → parity bit = 1. Send 0xFF → parity bit = 1 (8 ones, odd-inverted).
- ENABLE_PARITY=0, STOP_BITS=2, send 0x3C → 11 bit periods (44 clks): no parity slot, two high stop periods, then ready=1.
- valid held high with 0x11 then 0x22 → second handshake in the tx_done cycle; exactly 1 clk of tx=1 between the frames' stop bit and the next start bit.
- Reset pulse at clock 10 of a frame → tx=1 and ready=1 next edge; no tx_done. A fresh 0x5A sent afterwards is bit-exact.
- Loopback into the receiver (BAUD_DIV=434, 1000 random words, random valid gaps) → every received data_out equals the sent word; no receiver error.
